tetris_step_scheduler: RTL and testbench

Sequences every state-changing action the Tetris board engine performs. It owns the gravity timer, which is a level-scaled replacement for the fixed-rate game tick. It latches player move requests and arbitrates between them and gravity. It issues exactly one command at a time to the board engine over a valid/ready handshake. It sits between the input debouncers and the board/collision engine.

---
 rtl/tetris_sched_pkg.sv | 50 +++++
 rtl/tetris_step_scheduler_gravity_timer.sv | 29 ++
 rtl/tetris_step_scheduler.sv | 140 ++++++++++++++
 tb/tb_tetris_step_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_sched_pkg.sv
// Shared opcode/state encodings and arbitration helpers for the Tetris step scheduler.
package tetris_sched_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_DOWN  = 3'd1,
    OP_LEFT  = 3'd2,
    OP_RIGHT = 3'd3,
    OP_ROT   = 3'd4,
    OP_HARD  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam int PEND_W     = 5;
  localparam int PEND_DOWN  = 0;
  localparam int PEND_LEFT  = 1;
  localparam int PEND_RIGHT = 2;
  localparam int PEND_ROT   = 3;
  localparam int PEND_HARD  = 4;

  // Fixed priority: HARD > DOWN > ROT > LEFT > RIGHT.
  function automatic op_t pick_op(input logic [PEND_W-1:0] pend);
    if (pend[PEND_HARD])       return OP_HARD;
    else if (pend[PEND_DOWN])  return OP_DOWN;
    else if (pend[PEND_ROT])   return OP_ROT;
    else if (pend[PEND_LEFT])  return OP_LEFT;
    else if (pend[PEND_RIGHT]) return OP_RIGHT;
    else                       return OP_NONE;
  endfunction

  function automatic logic [PEND_W-1:0] op_mask(input op_t op);
    logic [PEND_W-1:0] m;
    m = '0;
    case (op)
      OP_DOWN:  m[PEND_DOWN]  = 1'b1;
      OP_LEFT:  m[PEND_LEFT]  = 1'b1;
      OP_RIGHT: m[PEND_RIGHT] = 1'b1;
      OP_ROT:   m[PEND_ROT]   = 1'b1;
      OP_HARD:  m[PEND_HARD]  = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tetris_step_scheduler_gravity_timer.sv
// Gravity counter: free-runs while run=1, reloads on reaching period-1 and pulses expire.
module gravity_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  output logic             expire
);

  logic [CNT_W-1:0] count_reg;
  logic             at_end;

  // ">=" rather than "==" so a shorter period mid-count expires at once.
  assign at_end = (count_reg >= (period - CNT_W'(1)));
  assign expire = run & at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (!run || at_end) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tetris_step_scheduler.sv
// Tetris step scheduler: gravity period, pending requests, arbitration and command handshake.
// Optional feature macro: TETRIS_SOFTDROP_EN (soft-drop period scaling).
module tetris_step_scheduler
  import tetris_sched_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 10_000_000,
  parameter int unsigned LEVEL_STEP  = 600_000,
  parameter int unsigned MIN_PERIOD  = 1_000_000,
  parameter int          CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] level,
  input  logic       soft_drop,
  input  logic       req_left,
  input  logic       req_right,
  input  logic       req_rot,
  input  logic       req_hard,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  input  logic       cmd_ready,
  output logic       tick_overrun
);

  localparam int PW = CNT_W + 4;

  logic [PW-1:0]    product;
  logic [PW-1:0]    level_period;
  logic [PW-1:0]    clamped_period;
  logic [PW-1:0]    period_sel;
  logic [CNT_W-1:0] period;
  logic             expire;

  assign product        = PW'(level) * PW'(LEVEL_STEP);
  assign level_period   = PW'(BASE_PERIOD) - product;
  assign clamped_period = (product >= PW'(BASE_PERIOD - MIN_PERIOD)) ? PW'(MIN_PERIOD)
                                                                     : level_period;

`ifdef TETRIS_SOFTDROP_EN
  logic [PW-1:0] fast_period;
  logic [PW-1:0] fast_floor;
  assign fast_floor  = PW'(MIN_PERIOD >> 2);
  assign fast_period = ((clamped_period >> 3) > fast_floor) ? (clamped_period >> 3) : fast_floor;
  assign period_sel  = soft_drop ? fast_period : clamped_period;
`else
  logic unused_soft_drop;
  assign unused_soft_drop = soft_drop;
  assign period_sel       = clamped_period;
`endif

  assign period = CNT_W'(period_sel);

  gravity_timer #(
    .CNT_W (CNT_W)
  ) u_gravity_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .period (period),
    .expire (expire)
  );

  state_t              state_reg, state_next;
  op_t                 cmd_op_reg, cmd_op_next;
  logic                cmd_valid_reg, cmd_valid_next;
  logic [PEND_W-1:0]   pend_reg, pend_next;
  logic [PEND_W-1:0]   pend_set, pend_clr;
  logic                overrun_reg, overrun_next;
  op_t                 win_op;

  assign win_op   = pick_op(pend_reg);
  assign pend_set = {req_hard, req_rot, req_right, req_left, expire} & {PEND_W{run}};

  always_comb begin
    state_next     = state_reg;
    cmd_valid_next = cmd_valid_reg;
    cmd_op_next    = cmd_op_reg;
    pend_clr       = '0;
    case (state_reg)
      ST_STOP: begin
        cmd_valid_next = 1'b0;
        cmd_op_next    = OP_NONE;
        if (run) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!run) begin
          state_next = ST_STOP;
        end else if (win_op != OP_NONE) begin
          cmd_op_next    = win_op;
          cmd_valid_next = 1'b1;
          pend_clr       = op_mask(win_op);
          state_next     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cmd_ready) begin
          cmd_valid_next = 1'b0;
          cmd_op_next    = OP_NONE;
          state_next     = run ? ST_RUN : ST_STOP;
          // A hard drop lands the piece, so a queued gravity step is stale.
          if (cmd_op_reg == OP_HARD) pend_clr[PEND_DOWN] = 1'b1;
        end
      end
      default: begin
        state_next     = ST_STOP;
        cmd_valid_next = 1'b0;
        cmd_op_next    = OP_NONE;
      end
    endcase

    // Sets are applied after clears so a request coinciding with its own issue re-arms.
    if (state_reg == ST_STOP) pend_next = '0;
    else                      pend_next = (pend_reg & ~pend_clr) | pend_set;

    if ((state_next == ST_STOP) && (state_reg != ST_STOP)) overrun_next = 1'b0;
    else overrun_next = overrun_reg | (expire & pend_reg[PEND_DOWN]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_STOP;
      cmd_valid_reg <= 1'b0;
      cmd_op_reg    <= OP_NONE;
      pend_reg      <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_valid_reg <= cmd_valid_next;
      cmd_op_reg    <= cmd_op_next;
      pend_reg      <= pend_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign cmd_valid    = cmd_valid_reg;
  assign cmd_op       = cmd_op_reg;
  assign tick_overrun = overrun_reg;

endmodule

// File: tb/tb_tetris_step_scheduler.sv
// Directed bench for tetris_step_scheduler with BASE_PERIOD=20, LEVEL_STEP=2, MIN_PERIOD=4.
module tb_tetris_step_scheduler;
  import tetris_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [3:0] level = 4'd0;
  logic       soft_drop = 1'b0;
  logic       req_left = 1'b0, req_right = 1'b0, req_rot = 1'b0, req_hard = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic       cmd_ready = 1'b0;
  logic       tick_overrun;

  tetris_step_scheduler #(
    .BASE_PERIOD (20),
    .LEVEL_STEP  (2),
    .MIN_PERIOD  (4),
    .CNT_W       (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .level        (level),
    .soft_drop    (soft_drop),
    .req_left     (req_left),
    .req_right    (req_right),
    .req_rot      (req_rot),
    .req_hard     (req_hard),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_ready    (cmd_ready),
    .tick_overrun (tick_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int run_start = 0;

`ifdef TETRIS_SOFTDROP_EN
  localparam int SD_FIRST = 3;
  localparam int SD_INT   = 2;
`else
  localparam int SD_FIRST = 21;
  localparam int SD_INT   = 20;
`endif

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Handshake monitor: logs accepted commands and checks hold/gap rules.
  int         acc_cyc[$];
  int         acc_op[$];
  logic       mon_en = 1'b0;
  logic       prev_stall = 1'b0;
  logic       prev_acc = 1'b0;
  logic [2:0] prev_op = 3'd0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check_value("hold_valid", {31'd0, cmd_valid}, 32'd1);
        check_value("hold_op", {29'd0, cmd_op}, {29'd0, prev_op});
      end
      if (prev_acc) check_value("gap_after_accept", {31'd0, cmd_valid}, 32'd0);
      if (cmd_valid && cmd_ready) begin
        acc_cyc.push_back(cyc);
        acc_op.push_back(int'(cmd_op));
        $display("accept cyc=%0d rel=%0d op=%0d", cyc, cyc - run_start, cmd_op);
      end
      prev_stall <= cmd_valid && !cmd_ready;
      prev_acc   <= cmd_valid && cmd_ready;
      prev_op    <= cmd_op;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    run = 1'b1;
    run_start = cyc;
  endtask

  task automatic to_rel(input int r);
    int guard;
    guard = 0;
    while ((cyc < run_start + r) && (guard < 1000)) begin
      tick(1);
      guard++;
    end
  endtask

  task automatic stop_and_clear();
    run = 1'b0;
    soft_drop = 1'b0;
    cmd_ready = 1'b1;
    tick(4);
    acc_cyc.delete();
    acc_op.delete();
  endtask

  // bits: {hard, rot, right, left}
  task automatic pulse(input logic [3:0] m);
    {req_hard, req_rot, req_right, req_left} = m;
    tick(1);
    {req_hard, req_rot, req_right, req_left} = 4'b0000;
  endtask

  task automatic wait_accepts(input int n, input int budget, input string tag);
    int g;
    g = 0;
    while ((acc_cyc.size() < n) && (g < budget)) begin
      tick(1);
      g++;
    end
    check_value(tag, acc_cyc.size(), n);
  endtask

  task automatic expect_acc(input int i, input op_t op, input int rel, input string tag);
    if (i < acc_cyc.size()) begin
      check_value({tag, "_op"}, acc_op[i], int'(op));
      check_value({tag, "_cyc"}, acc_cyc[i] - run_start, rel);
    end else begin
      check_value({tag, "_missing"}, acc_cyc.size(), i + 1);
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    check_value("rst_valid", {31'd0, cmd_valid}, 32'd0);
    check_value("rst_op", {29'd0, cmd_op}, 32'd0);
    check_value("rst_overrun", {31'd0, tick_overrun}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    mon_en = 1'b1;

    // Request latency, LEFT/RIGHT ordering, same-cycle re-request
    cmd_ready = 1'b1;
    level = 4'd0;
    start_run();
    to_rel(3);
    pulse(4'b0011);
    to_rel(10);
    pulse(4'b0100);
    pulse(4'b0100);
    wait_accepts(5, 100, "lat_count");
    expect_acc(0, OP_LEFT, 5, "lat_left");
    expect_acc(1, OP_RIGHT, 7, "lat_right");
    expect_acc(2, OP_ROT, 12, "lat_rot1");
    expect_acc(3, OP_ROT, 14, "lat_rot2");
    expect_acc(4, OP_DOWN, 21, "lat_down");

    // Gravity at level 0
    stop_and_clear();
    start_run();
    wait_accepts(3, 200, "l0_count");
    expect_acc(0, OP_DOWN, 21, "l0_a");
    expect_acc(1, OP_DOWN, 41, "l0_b");
    expect_acc(2, OP_DOWN, 61, "l0_c");

    // Level 3 -> period 14
    stop_and_clear();
    level = 4'd3;
    start_run();
    wait_accepts(3, 200, "l3_count");
    expect_acc(0, OP_DOWN, 15, "l3_a");
    expect_acc(1, OP_DOWN, 29, "l3_b");
    expect_acc(2, OP_DOWN, 43, "l3_c");

    // Level 15 -> clamped to 4
    stop_and_clear();
    level = 4'd15;
    start_run();
    wait_accepts(3, 200, "l15_count");
    expect_acc(0, OP_DOWN, 5, "l15_a");
    expect_acc(1, OP_DOWN, 9, "l15_b");
    expect_acc(2, OP_DOWN, 13, "l15_c");

    // Soft drop at level 0
    stop_and_clear();
    level = 4'd0;
    soft_drop = 1'b1;
    start_run();
    wait_accepts(3, 200, "sd_count");
    expect_acc(0, OP_DOWN, SD_FIRST, "sd_a");
    expect_acc(1, OP_DOWN, SD_FIRST + SD_INT, "sd_b");
    expect_acc(2, OP_DOWN, SD_FIRST + 2 * SD_INT, "sd_c");

    // Arbitration: DOWN pending plus LEFT/ROT/HARD in one cycle
    stop_and_clear();
    cmd_ready = 1'b0;
    start_run();
    to_rel(45);
    check_value("arb_valid", {31'd0, cmd_valid}, 32'd1);
    check_value("arb_held_op", {29'd0, cmd_op}, int'(OP_DOWN));
    pulse(4'b1101);
    to_rel(47);
    cmd_ready = 1'b1;
    wait_accepts(5, 100, "arb_count");
    expect_acc(0, OP_DOWN, 47, "arb_down");
    expect_acc(1, OP_HARD, 49, "arb_hard");
    expect_acc(2, OP_ROT, 51, "arb_rot");
    expect_acc(3, OP_LEFT, 53, "arb_left");
    expect_acc(4, OP_DOWN, 61, "arb_next_down");
    check_value("arb_no_overrun", {31'd0, tick_overrun}, 32'd0);

    // Back-pressure, overrun, then stop while waiting
    stop_and_clear();
    cmd_ready = 1'b0;
    start_run();
    to_rel(30);
    check_value("bp_valid", {31'd0, cmd_valid}, 32'd1);
    check_value("bp_op", {29'd0, cmd_op}, int'(OP_DOWN));
    check_value("bp_overrun_early", {31'd0, tick_overrun}, 32'd0);
    to_rel(55);
    check_value("bp_overrun_mid", {31'd0, tick_overrun}, 32'd0);
    to_rel(65);
    check_value("bp_overrun_set", {31'd0, tick_overrun}, 32'd1);
    pulse(4'b0010);
    to_rel(68);
    run = 1'b0;
    to_rel(70);
    cmd_ready = 1'b1;
    to_rel(72);
    check_value("stop_overrun_clr", {31'd0, tick_overrun}, 32'd0);
    check_value("stop_valid", {31'd0, cmd_valid}, 32'd0);
    to_rel(95);
    check_value("stop_accept_count", acc_cyc.size(), 1);
    expect_acc(0, OP_DOWN, 70, "stop_accept");
    acc_cyc.delete();
    acc_op.delete();
    start_run();
    wait_accepts(1, 100, "restart_count");
    expect_acc(0, OP_DOWN, 21, "restart_first");

    run = 1'b0;
    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
